// File: rtl/spi_reg_bridge.sv
// SPI (mode 0) slave to register-bus bridge: cmd byte {rw,rsvd,addr[5:0]} then data byte(s).
// Define SPI_AUTOINC_EN to enable burst addressing (addr+1 per extra byte, wrapping at 6'h3F).
module spi_reg_bridge (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       read,
  output logic       write,
  output logic [5:0] addr,
  output logic [7:0] data_write,
  input  logic [7:0] data_read,
  output logic       busy,
  output logic       frame_err
);

`ifdef SPI_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, CMD, RD_REQ, RD_CAP, DATA, WR_STB} state_t;

  state_t      r_state, w_nxt;
  logic [2:0]  r_sclk_s, r_cs_s;
  logic [1:0]  r_mosi_s;
  logic [2:0]  r_bitcnt;
  logic [6:0]  r_sh;
  logic [7:0]  r_tx;
  logic [7:0]  r_wdata;
  logic [5:0]  r_addr;
  logic        r_rw, r_done, r_miso, r_ferr;
  logic        w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_mosi, w_byte_end;

  // Stage [2] of each 3-flop chain is only the edge-detect history.
  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_s[2];
  assign w_cs_rise   = r_cs_s[1] & ~r_cs_s[2];
  assign w_cs_fall   = ~r_cs_s[1] & r_cs_s[2];
  assign w_mosi      = r_mosi_s[1];
  assign w_byte_end  = w_sclk_rise & (r_bitcnt == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_s <= '0;
      r_cs_s   <= '0;
      r_mosi_s <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], sclk};
      r_cs_s   <= {r_cs_s[1:0], cs_n};
      r_mosi_s <= {r_mosi_s[0], mosi};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    read  = 1'b0;
    write = 1'b0;
    if (r_state != IDLE && w_cs_rise) begin
      w_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:   if (w_cs_fall) w_nxt = CMD;
        CMD:    if (w_byte_end) w_nxt = r_sh[6] ? DATA : RD_REQ;
        RD_REQ: begin
          read  = 1'b1;
          w_nxt = RD_CAP;
        end
        RD_CAP: w_nxt = DATA;
        DATA:   if (w_byte_end && !r_done) begin
          if (r_rw)         w_nxt = WR_STB;
          else if (AUTOINC) w_nxt = RD_REQ;
          else              w_nxt = DATA;
        end
        WR_STB: begin
          write = 1'b1;
          w_nxt = DATA;
        end
        default: w_nxt = IDLE;
      endcase
    end
  end

  // r_done marks the single data byte as consumed; later bytes only keep the bit count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt <= '0;
      r_sh     <= '0;
      r_tx     <= '0;
      r_wdata  <= '0;
      r_addr   <= '0;
      r_rw     <= 1'b0;
      r_done   <= 1'b0;
      r_miso   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      if (r_state == IDLE) begin
        r_bitcnt <= '0;
        r_done   <= 1'b0;
        r_tx     <= '0;
        r_miso   <= 1'b0;
      end else if (w_cs_rise) begin
        r_ferr <= (r_bitcnt != 3'd0);
        r_miso <= 1'b0;
      end else begin
        if (w_sclk_rise) begin
          r_bitcnt <= r_bitcnt + 3'd1;
          r_sh     <= {r_sh[5:0], w_mosi};
        end
        if (r_state == CMD && w_byte_end) begin
          r_rw   <= r_sh[6];
          r_addr <= {r_sh[4:0], w_mosi};
        end
        if (r_state == DATA && w_byte_end && !r_done) begin
          if (r_rw)         r_wdata <= {r_sh, w_mosi};
          else if (AUTOINC) r_addr  <= r_addr + 6'd1;
          else              r_done  <= 1'b1;
        end
        if (r_state == DATA && w_sclk_fall) begin
          r_miso <= r_tx[7] & ~r_done;
          r_tx   <= {r_tx[6:0], 1'b0};
        end
        if (r_state == RD_CAP) r_tx <= data_read;
        if (r_state == WR_STB) begin
          if (AUTOINC) r_addr <= r_addr + 6'd1;
          else         r_done <= 1'b1;
        end
      end
    end
  end

  assign miso       = r_miso;
  assign addr       = r_addr;
  assign data_write = r_wdata;
  assign busy       = (r_state != IDLE);
  assign frame_err  = r_ferr;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: vector table, corner sequences, random frames vs a frame-level model.
module tb_spi_reg_bridge;
`ifdef SPI_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       miso, rd, wr, busy, frame_err;
  logic [5:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read = 8'h00;

  always #5 clk = ~clk;

  spi_reg_bridge dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .read(rd), .write(wr), .addr(addr), .data_write(data_write),
    .data_read(data_read), .busy(busy), .frame_err(frame_err)
  );

  // Register file seen by the bridge, and the model's own view of it.
  logic [7:0] mem[64];
  logic [7:0] ref_mem[64];
  always @(posedge clk) begin
    if (rd) data_read <= mem[addr];
    if (wr) mem[addr] <= data_write;
  end

  int          n_ferr, n_ovl;
  logic [13:0] wrq[$];
  logic [5:0]  rdq[$];
  always @(negedge clk) if (!rst) begin
    if (wr) wrq.push_back({addr, data_write});
    if (rd) rdq.push_back(addr);
    if (rd && wr) n_ovl++;
    if (frame_err) n_ferr++;
  end

  int total = 0, bad = 0, h = 10, nb;
  logic [7:0]  fb[4], rxb[4], emiso[4];
  logic [13:0] ewr[$];
  logic [5:0]  erd[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      wait_clk(h);
      rx[i] = miso;
      sclk = 1'b1;
      wait_clk(h);
      sclk = 1'b0;
    end
  endtask

  task automatic clr_mon;
    wrq.delete(); rdq.delete(); n_ferr = 0; n_ovl = 0;
  endtask

  task automatic run_frame;
    clr_mon();
    cs_n = 1'b0;
    wait_clk(h);
    for (int j = 0; j < nb; j++) xfer(fb[j], 8, rxb[j]);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  // Frame semantics: byte 1 hits cmd addr; with bursts byte j hits addr+j-1 (mod 64),
  // and a read frame prefetches after every completed byte.
  task automatic model_frame;
    logic [5:0] t;
    ewr.delete(); erd.delete();
    emiso[0] = 8'h00;
    for (int j = 1; j < nb; j++) begin
      emiso[j] = 8'h00;
      if (j == 1 || AI) begin
        t = 6'((fb[0][5:0] + j - 1) % 64);
        if (fb[0][7]) begin
          ref_mem[t] = fb[j];
          ewr.push_back({t, fb[j]});
        end else begin
          erd.push_back(t);
          emiso[j] = ref_mem[t];
        end
      end
    end
    if (AI && !fb[0][7]) erd.push_back(6'((fb[0][5:0] + nb - 1) % 64));
  endtask

  task automatic check_frame(input string nm);
    chk({nm, " nwr"}, wrq.size(), ewr.size());
    for (int k = 0; k < ewr.size() && k < wrq.size(); k++) chk({nm, " wr"}, wrq[k], ewr[k]);
    chk({nm, " nrd"}, rdq.size(), erd.size());
    for (int k = 0; k < erd.size() && k < rdq.size(); k++) chk({nm, " rdaddr"}, rdq[k], erd[k]);
    for (int j = 0; j < nb; j++) chk($sformatf("%s miso%0d", nm, j), rxb[j], emiso[j]);
    chk({nm, " ferr"}, n_ferr, 0);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " overlap"}, n_ovl, 0);
  endtask

  typedef struct {
    logic [7:0] cmd, dat;
    int         nwr, nrd;
    logic [5:0] ea;
    logic [7:0] ewd, emi;
  } vec_t;
  vec_t tbl[7];

  initial begin
    logic [7:0] r;
    tbl[0] = '{8'h81, 8'h5A, 1, 0, 6'h01, 8'h5A, 8'h00};
    tbl[1] = '{8'h08, 8'h00, 0, 1, 6'h08, 8'h00, 8'hCD};
    tbl[2] = '{8'hC5, 8'hA3, 1, 0, 6'h05, 8'hA3, 8'h00};
    tbl[3] = '{8'h45, 8'h77, 0, 1, 6'h05, 8'h00, 8'hA3};
    tbl[4] = '{8'h01, 8'hFF, 0, 1, 6'h01, 8'h00, 8'h5A};
    tbl[5] = '{8'hBF, 8'hE7, 1, 0, 6'h3F, 8'hE7, 8'h00};
    tbl[6] = '{8'h3F, 8'h00, 0, 1, 6'h3F, 8'h00, 8'hE7};
    for (int i = 0; i < 64; i++) mem[i] = 8'((i * 53 + 17) % 256);
    mem[8] = 8'hCD;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];

    wait_clk(3);
    chk("reset outputs", {miso, rd, wr, busy, frame_err, addr, data_write}, 0);
    rst = 1'b0;
    wait_clk(5);

    nb = 2;
    for (int i = 0; i < 7; i++) begin
      fb[0] = tbl[i].cmd; fb[1] = tbl[i].dat;
      run_frame();
      chk($sformatf("vec%0d nwr", i), wrq.size(), tbl[i].nwr);
      chk($sformatf("vec%0d nrd", i), rdq.size(), tbl[i].nrd);
      if (tbl[i].nwr > 0 && wrq.size() > 0)
        chk($sformatf("vec%0d wr", i), wrq[0], {tbl[i].ea, tbl[i].ewd});
      if (tbl[i].nrd > 0 && rdq.size() > 0)
        chk($sformatf("vec%0d rdaddr", i), rdq[0], tbl[i].ea);
      chk($sformatf("vec%0d cmd miso", i), rxb[0], 0);
      chk($sformatf("vec%0d miso", i), rxb[1], tbl[i].emi);
      chk($sformatf("vec%0d ferr", i), n_ferr, 0);
      if (tbl[i].nwr > 0) ref_mem[tbl[i].ea] = tbl[i].ewd;
    end

    // cs_n rises 4 bits into the data byte of a write frame
    clr_mon();
    cs_n = 1'b0; wait_clk(h);
    xfer(8'h83, 8, r);
    xfer(8'h5A, 4, r);
    cs_n = 1'b1;
    wait_clk(4);
    chk("midbyte busy", busy, 0);
    wait_clk(6);
    chk("midbyte nwr", wrq.size(), 0);
    chk("midbyte ferr", n_ferr, 1);

    // cs_n rises exactly on a byte boundary
    clr_mon();
    cs_n = 1'b0; wait_clk(h);
    xfer(8'h84, 8, r);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
    chk("boundary nwr", wrq.size(), 0);
    chk("boundary ferr", n_ferr, 0);

    // reset during the cmd byte; no frame until a fresh cs_n fall
    clr_mon();
    cs_n = 1'b0; wait_clk(h);
    xfer(8'h82, 3, r);
    rst = 1'b1;
    wait_clk(2);
    chk("midreset outputs", {miso, rd, wr, busy, frame_err, addr, data_write}, 0);
    rst = 1'b0;
    wait_clk(3);
    xfer(8'h82, 8, r);
    xfer(8'h33, 8, r);
    wait_clk(4);
    chk("post-reset idle busy", busy, 0);
    chk("post-reset no strobes", wrq.size() + rdq.size(), 0);
    cs_n = 1'b1;
    wait_clk(8);
    nb = 2; fb[0] = 8'h82; fb[1] = 8'h11;
    model_frame(); run_frame(); check_frame("after reset");
    if (wrq.size() > 0) chk("after reset wr", wrq[0], {6'h02, 8'h11});

    // burst write across the address wrap, then burst read back
    nb = 3; fb[0] = 8'hBF; fb[1] = 8'h01; fb[2] = 8'h02;
    model_frame(); run_frame(); check_frame("burst wr");
    chk("burst wr count", wrq.size(), AI ? 2 : 1);
    if (wrq.size() > 0) chk("burst wr first", wrq[0], {6'h3F, 8'h01});
    nb = 4; fb[0] = 8'h3F; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00;
    model_frame(); run_frame(); check_frame("burst rd");

    for (int n = 0; n < 24; n++) begin
      h  = $urandom_range(8, 14);
      nb = $urandom_range(2, 4);
      for (int j = 0; j < 4; j++) fb[j] = 8'($urandom);
      model_frame(); run_frame(); check_frame($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
